// File: rtl/sprite_pixel_renderer_pkg.sv
// Shared constants, sprite geometry and position-FSM types for the sprite renderer.
// SPRITE_SCALE2_EN selects a 32x32 box where each mask bit covers 2x2 pixels.
package sprite_pixel_renderer_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam logic [2:0] SPR_COLOR_DEF = 3'b100;
  localparam logic [2:0] BG_COLOR_DEF  = 3'b001;
  localparam logic [2:0] BLANK_COLOR   = 3'b000;

`ifdef SPRITE_SCALE2_EN
  localparam int SPR_SIZE = 32;
  localparam int SPR_LOG2 = 5;
`else
  localparam int SPR_SIZE = 16;
  localparam int SPR_LOG2 = 4;
`endif

  typedef enum logic {
    POS_IDLE    = 1'b0,
    POS_PENDING = 1'b1
  } pos_state_e;

  function automatic logic [9:0] clamp_pos(input logic [9:0] req, input logic [9:0] lim);
    return (req > lim) ? lim : req;
  endfunction

endpackage

// File: rtl/sprite_pos_latch.sv
// Sprite position handshake: captures a clamped request, then commits it to the
// active position on the next frame-start pulse so a frame never tears.
module sprite_pos_latch
  import sprite_pixel_renderer_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [9:0] iPosX,
  input  logic [9:0] iPosY,
  input  logic       iPosValid,
  input  logic       iFrameStart,
  output logic       oPosReady,
  output logic [9:0] oActX,
  output logic [9:0] oActY
);

  localparam logic [9:0] X_MAX = 10'(H_ACTIVE - SPR_SIZE);
  localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - SPR_SIZE);

  pos_state_e r_state, w_next_state;
  logic [9:0] r_pend_x, r_pend_y;
  logic [9:0] r_act_x, r_act_y;
  logic       w_capture, w_commit;

  // NOTE: sequential state uses non-blocking assignments only; the synchronous
  // reset clears every register, including pending, so a reset drops any request.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= POS_IDLE;
      r_pend_x <= '0;
      r_pend_y <= '0;
      r_act_x  <= '0;
      r_act_y  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_pend_x <= clamp_pos(iPosX, X_MAX);
        r_pend_y <= clamp_pos(iPosY, Y_MAX);
      end
      if (w_commit) begin
        r_act_x <= r_pend_x;
        r_act_y <= r_pend_y;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_commit     = 1'b0;
    oPosReady    = 1'b0;
    unique case (r_state)
      POS_IDLE: begin
        oPosReady = 1'b1;
        // A frame-start in the same cycle is ignored: the commit waits a full frame.
        if (iPosValid) begin
          w_capture    = 1'b1;
          w_next_state = POS_PENDING;
        end
      end
      POS_PENDING: begin
        if (iFrameStart) begin
          w_commit     = 1'b1;
          w_next_state = POS_IDLE;
        end
      end
      default: w_next_state = POS_IDLE;
    endcase
  end

  assign oActX = r_act_x;
  assign oActY = r_act_y;

endmodule

// File: rtl/sprite_pixel_renderer.sv
// Two-stage sprite pixel pipeline: box test and mask-ROM address, then colour.
// Build with SPRITE_SCALE2_EN for a 2x-scaled (32x32) sprite.
module sprite_pixel_renderer
  import sprite_pixel_renderer_pkg::*;
#(
  parameter int         H_ACTIVE  = H_ACTIVE_DEF,
  parameter int         V_ACTIVE  = V_ACTIVE_DEF,
  parameter logic [2:0] SPR_COLOR = SPR_COLOR_DEF,
  parameter logic [2:0] BG_COLOR  = BG_COLOR_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [9:0] iPixelX,
  input  logic [9:0] iPixelY,
  input  logic       iVideoOn,
  input  logic       iFrameStart,
  input  logic [9:0] iPosX,
  input  logic [9:0] iPosY,
  input  logic       iPosValid,
  output logic       oPosReady,
  output logic [7:0] oRomAddress,
  input  logic       iMask,
  output logic [2:0] oColor,
  output logic       oVideoOn,
  output logic       oHit
);

  logic [9:0] w_act_x, w_act_y;
  logic [3:0] w_dx_nib, w_dy_nib;
  logic       w_in_x, w_in_y, w_in_box, w_opaque;
  logic       r_s1_in, r_s1_vid;

  sprite_pos_latch #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pos_latch (
    .Clock       (Clock),
    .Reset       (Reset),
    .iPosX       (iPosX),
    .iPosY       (iPosY),
    .iPosValid   (iPosValid),
    .iFrameStart (iFrameStart),
    .oPosReady   (oPosReady),
    .oActX       (w_act_x),
    .oActY       (w_act_y)
  );

  // Compare in 11 bits so actX+SPR_SIZE up to the screen edge cannot wrap.
  assign w_in_x   = ({1'b0, iPixelX} >= {1'b0, w_act_x}) &&
                    ({1'b0, iPixelX} <  ({1'b0, w_act_x} + 11'(SPR_SIZE)));
  assign w_in_y   = ({1'b0, iPixelY} >= {1'b0, w_act_y}) &&
                    ({1'b0, iPixelY} <  ({1'b0, w_act_y} + 11'(SPR_SIZE)));
  assign w_in_box = iVideoOn && w_in_x && w_in_y;

  // Offset into the box, dropping the low bit when each mask bit spans 2x2 pixels.
  assign w_dx_nib = 4'((iPixelX - w_act_x) >> (SPR_LOG2 - 4));
  assign w_dy_nib = 4'((iPixelY - w_act_y) >> (SPR_LOG2 - 4));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      oRomAddress <= '0;
      r_s1_in     <= 1'b0;
      r_s1_vid    <= 1'b0;
    end else begin
      oRomAddress <= w_in_box ? {w_dy_nib, w_dx_nib} : 8'h00;
      r_s1_in     <= w_in_box;
      r_s1_vid    <= iVideoOn;
    end
  end

  // iMask answers the address registered in stage 1, so it lines up with r_s1_in.
  assign w_opaque = r_s1_in & ~iMask;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      oColor   <= BLANK_COLOR;
      oVideoOn <= 1'b0;
      oHit     <= 1'b0;
    end else begin
      oVideoOn <= r_s1_vid;
      oHit     <= w_opaque;
      oColor   <= !r_s1_vid ? BLANK_COLOR : (w_opaque ? SPR_COLOR : BG_COLOR);
    end
  end

endmodule
